// File: rtl/ball_physics.sv
// ball_physics: per-frame ball position/velocity engine with walls, kicks, friction, goals and serve sequencing
module ball_physics #(
  parameter int W          = 10,
  parameter int NPLAYERS   = 2,
  parameter int BALL_SIZE  = 4,
  parameter int X_MIN      = 20,
  parameter int X_MAX      = 619,
  parameter int Y_MIN      = 19,
  parameter int Y_MAX      = 459,
  parameter int X_CENTER   = 320,
  parameter int Y_CENTER   = 240,
  parameter int GOAL_Y_LO  = 200,
  parameter int GOAL_Y_HI  = 280,
  parameter int KICK       = 3,
  parameter int VMAX       = 12,
  parameter int FRIC_DIV   = 4,
  parameter int GOAL_HOLD  = 60,
  parameter int SERVE_HOLD = 30
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic [NPLAYERS*W-1:0] play_x,
  input  logic [NPLAYERS*W-1:0] play_y,
  input  logic [NPLAYERS*W-1:0] play_vx,
  input  logic [NPLAYERS*W-1:0] play_vy,
  input  logic [NPLAYERS*W-1:0] play_size,
  input  logic                  friction_en,
  input  logic                  center_ball,
  output logic [W-1:0]          ball_x,
  output logic [W-1:0]          ball_y,
  output logic [W-1:0]          ball_s,
  output logic [W-1:0]          ball_vx,
  output logic [W-1:0]          ball_vy,
  output logic                  goal_left,
  output logic                  goal_right,
  output logic [3:0]            goals_left,
  output logic [3:0]            goals_right,
  output logic [1:0]            phase
);
  localparam logic [1:0] SERVE = 2'd0, PLAY = 2'd1, HOLD = 2'd2;
  localparam logic [W-1:0] XL = W'(X_MIN + BALL_SIZE), XH = W'(X_MAX - BALL_SIZE);
  localparam logic [W-1:0] YL = W'(Y_MIN + BALL_SIZE), YH = W'(Y_MAX - BALL_SIZE);
  localparam logic [W-1:0] XC = W'(X_CENTER), YC = W'(Y_CENTER);
  localparam logic [W-1:0] GYL = W'(GOAL_Y_LO), GYH = W'(GOAL_Y_HI);
  localparam logic [15:0] SERVE_T = 16'(SERVE_HOLD), GOAL_T = 16'(GOAL_HOLD);
  localparam logic [7:0] FMASK = 8'(FRIC_DIV - 1);

  logic [1:0] phase_q, phase_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0] vx_q, vx_d, vy_q, vy_d, sel_vx, sel_vy;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] fric_q, fric_d;
  logic [3:0] gl_q, gl_d, gr_q, gr_d;
  logic pl_q, pl_d, pr_q, pr_d;
  logic [NPLAYERS-1:0] hit_v;
  logic at_l, at_r, at_t, at_b, mouth, goal_l, goal_r, wall_x, wall_y, hit, cnt_zero, recenter;

  function automatic logic signed [W-1:0] kick(input logic signed [W-1:0] pv, input logic signed [W-1:0] bv);
    int t;
    t = pv > 0 ? int'(pv) + KICK : pv < 0 ? int'(pv) - KICK : int'(bv);
    return W'(t > VMAX ? VMAX : t < -VMAX ? -VMAX : t);
  endfunction

  function automatic logic signed [W-1:0] bounce(input logic signed [W-1:0] v, input logic neg);
    int m;
    m = v < 0 ? -int'(v) : int'(v);
    m = m == 0 ? 1 : m;
    return W'(neg ? -m : m);
  endfunction

  function automatic logic signed [W-1:0] damp(input logic signed [W-1:0] v);
    return W'(int'(v) - (v > 0 ? 1 : v < 0 ? -1 : 0));
  endfunction

  function automatic logic [W-1:0] step(input logic [W-1:0] p, input logic signed [W-1:0] v, input int lo, input int hi);
    int t;
    t = int'(p) + int'(v);
    return W'(t < lo ? lo : t > hi ? hi : t);
  endfunction

  assign at_l     = x_q <= XL;
  assign at_r     = x_q >= XH;
  assign at_t     = y_q <= YL;
  assign at_b     = y_q >= YH;
  assign mouth    = y_q >= GYL && y_q <= GYH;
  assign goal_l   = phase_q == PLAY && !center_ball && at_l && mouth;
  assign goal_r   = phase_q == PLAY && !center_ball && at_r && mouth && !at_l;
  assign wall_x   = at_l || at_r;
  assign wall_y   = at_t || at_b;
  assign hit      = |hit_v;
  assign cnt_zero = cnt_q == 16'd0;
  assign recenter = center_ball || (phase_q == HOLD && cnt_zero);

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_hit
    logic [W-1:0] px, py, dx, dy;
    logic [W:0] reach;
    assign px       = play_x[i*W +: W];
    assign py       = play_y[i*W +: W];
    assign dx       = x_q >= px ? x_q - px : px - x_q;
    assign dy       = y_q >= py ? y_q - py : py - y_q;
    assign reach    = (W+1)'(BALL_SIZE) + {1'b0, play_size[i*W +: W]};
    assign hit_v[i] = {1'b0, dx} <= reach && {1'b0, dy} <= reach;
  end

  // walking down from the top index leaves the lowest-index contact selected
  always_comb begin
    sel_vx = '0;
    sel_vy = '0;
    for (int k = NPLAYERS - 1; k >= 0; k--)
      if (hit_v[k]) begin
        sel_vx = play_vx[k*W +: W];
        sel_vy = play_vy[k*W +: W];
      end
  end

  always_ff @(posedge frame_clk) phase_q <= !Reset_n ? SERVE : phase_d;

  always_comb
    phase_d = center_ball ? SERVE :
              (phase_q == SERVE && cnt_zero) ? PLAY :
              (phase_q == HOLD && cnt_zero) ? SERVE :
              (goal_l || goal_r) ? HOLD : phase_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    cnt_d  = cnt_zero ? cnt_q : cnt_q - 16'd1;
    fric_d = fric_q;
    gl_d   = gl_q + 4'(goal_l && gl_q != 4'hf);
    gr_d   = gr_q + 4'(goal_r && gr_q != 4'hf);
    pl_d   = goal_l;
    pr_d   = goal_r;
    if (center_ball || phase_q != PLAY || goal_l || goal_r) begin
      vx_d = '0;
      vy_d = '0;
    end
    if (recenter || phase_q == SERVE) begin
      x_d = XC;
      y_d = YC;
    end
    if (recenter) cnt_d = SERVE_T;
    else if (goal_l || goal_r) cnt_d = GOAL_T;
    else if (phase_q == PLAY) begin
      vx_d = wall_x ? bounce(vx_q, at_r) : hit ? kick(sel_vx, vx_q) : vx_q;
      vy_d = wall_y ? bounce(vy_q, at_b) : hit ? kick(sel_vy, vy_q) : vy_q;
      if (!(wall_x || wall_y || hit)) begin
        fric_d = (fric_q + 8'd1) & FMASK;
        if (fric_q == 8'd0 && friction_en) begin
          vx_d = damp(vx_q);
          vy_d = damp(vy_q);
        end
      end
      x_d = step(x_q, vx_q, X_MIN + BALL_SIZE, X_MAX - BALL_SIZE);
      y_d = step(y_q, vy_q, Y_MIN + BALL_SIZE, Y_MAX - BALL_SIZE);
    end
  end

  always_ff @(posedge frame_clk)
    if (!Reset_n) begin
      x_q    <= XC;
      y_q    <= YC;
      vx_q   <= '0;
      vy_q   <= '0;
      cnt_q  <= SERVE_T;
      fric_q <= '0;
      gl_q   <= '0;
      gr_q   <= '0;
      pl_q   <= 1'b0;
      pr_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      cnt_q  <= cnt_d;
      fric_q <= fric_d;
      gl_q   <= gl_d;
      gr_q   <= gr_d;
      pl_q   <= pl_d;
      pr_q   <= pr_d;
    end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign ball_s      = W'(BALL_SIZE);
  assign ball_vx     = vx_q;
  assign ball_vy     = vy_q;
  assign goal_left   = pl_q;
  assign goal_right  = pr_q;
  assign goals_left  = gl_q;
  assign goals_right = gr_q;
  assign phase       = phase_q;
endmodule

// File: tb/tb_ball_physics.sv
// tb_ball_physics: directed scenarios for ball_physics with hand-derived trajectories
module tb_ball_physics;
  logic frame_clk = 1'b0, Reset_n = 1'b0, friction_en = 1'b0, center_ball = 1'b0;
  logic [19:0] play_x, play_y, play_vx, play_vy, play_size;
  logic [9:0] ball_x, ball_y, ball_s, ball_vx, ball_vy;
  logic goal_left, goal_right;
  logic [3:0] goals_left, goals_right;
  logic [1:0] phase;
  int checks = 0, failures = 0;

  ball_physics dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .play_x(play_x), .play_y(play_y),
    .play_vx(play_vx), .play_vy(play_vy), .play_size(play_size), .friction_en(friction_en),
    .center_ball(center_ball), .ball_x(ball_x), .ball_y(ball_y), .ball_s(ball_s),
    .ball_vx(ball_vx), .ball_vy(ball_vy), .goal_left(goal_left), .goal_right(goal_right),
    .goals_left(goals_left), .goals_right(goals_right), .phase(phase)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic set_p(input int k, input int x, input int y, input int vx, input int vy);
    play_x[k*10 +: 10]    = 10'(x);
    play_y[k*10 +: 10]    = 10'(y);
    play_vx[k*10 +: 10]   = 10'(vx);
    play_vy[k*10 +: 10]   = 10'(vy);
    play_size[k*10 +: 10] = 10'd4;
  endtask

  task automatic park();
    set_p(0, 100, 440, 0, 0);
    set_p(1, 100, 440, 0, 0);
  endtask

  task automatic go_play();
    Reset_n = 1'b0;
    tick(1);
    Reset_n = 1'b1;
    tick(31);
  endtask

  task automatic test_reset();
    park();
    Reset_n = 1'b0;
    tick(1);
    Reset_n = 1'b1;
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240) begin failures++; $display("FAIL reset_pos got (%0d,%0d) exp (320,240)", ball_x, ball_y); end
    checks++;
    if (ball_vx !== 10'd0 || ball_vy !== 10'd0 || ball_s !== 10'd4) begin failures++; $display("FAIL reset_v got v=(%0d,%0d) s=%0d exp (0,0) s=4", $signed(ball_vx), $signed(ball_vy), ball_s); end
    checks++;
    if (phase !== 2'd0 || goals_left !== 4'd0 || goals_right !== 4'd0 || goal_left !== 1'b0 || goal_right !== 1'b0) begin failures++; $display("FAIL reset_state got phase=%0d gl=%0d gr=%0d pulses=%b%b exp 0 0 0 00", phase, goals_left, goals_right, goal_left, goal_right); end
    tick(30);
    checks++;
    if (phase !== 2'd0) begin failures++; $display("FAIL serve_hold30 got phase=%0d exp 0", phase); end
    tick(1);
    checks++;
    if (phase !== 2'd1) begin failures++; $display("FAIL serve_to_play got phase=%0d exp 1", phase); end
  endtask

  task automatic test_wall();
    park();
    set_p(0, 320, 240, 11, -1);
    go_play();
    tick(1);
    checks++;
    if (ball_vx !== 10'd12 || ball_vy !== 10'(-4)) begin failures++; $display("FAIL kick_sat got (%0d,%0d) exp (12,-4)", $signed(ball_vx), $signed(ball_vy)); end
    park();
    tick(10);
    checks++;
    if (ball_vx !== 10'd12 || ball_x !== 10'd440) begin failures++; $display("FAIL no_friction got vx=%0d x=%0d exp 12 440", $signed(ball_vx), ball_x); end
    tick(15);
    checks++;
    if (ball_x !== 10'd615 || ball_vx !== 10'd12) begin failures++; $display("FAIL wall_reach got x=%0d vx=%0d exp 615 12", ball_x, $signed(ball_vx)); end
    tick(1);
    checks++;
    if (ball_vx !== 10'(-12) || ball_vy !== 10'(-4) || ball_x !== 10'd615) begin failures++; $display("FAIL wall_bounce got v=(%0d,%0d) x=%0d exp (-12,-4) 615", $signed(ball_vx), $signed(ball_vy), ball_x); end
    tick(1);
    checks++;
    if (ball_x !== 10'd603) begin failures++; $display("FAIL wall_move got x=%0d exp 603", ball_x); end
  endtask

  task automatic test_corner();
    park();
    set_p(0, 320, 240, 11, -6);
    go_play();
    tick(1);
    checks++;
    if (ball_vx !== 10'd12 || ball_vy !== 10'(-9)) begin failures++; $display("FAIL corner_kick got (%0d,%0d) exp (12,-9)", $signed(ball_vx), $signed(ball_vy)); end
    park();
    tick(25);
    checks++;
    if (ball_x !== 10'd615 || ball_y !== 10'd23 || ball_vx !== 10'd12 || ball_vy !== 10'(-9)) begin failures++; $display("FAIL corner_reach got (%0d,%0d) v=(%0d,%0d) exp (615,23) (12,-9)", ball_x, ball_y, $signed(ball_vx), $signed(ball_vy)); end
    tick(1);
    checks++;
    if (ball_vx !== 10'(-12) || ball_vy !== 10'd9) begin failures++; $display("FAIL corner_bounce got (%0d,%0d) exp (-12,9)", $signed(ball_vx), $signed(ball_vy)); end
    tick(1);
    checks++;
    if (ball_x !== 10'd603 || ball_y !== 10'd32) begin failures++; $display("FAIL corner_move got (%0d,%0d) exp (603,32)", ball_x, ball_y); end
  endtask

  task automatic test_kick_still();
    park();
    set_p(0, 320, 240, -2, 0);
    go_play();
    tick(1);
    checks++;
    if (ball_vx !== 10'(-5) || ball_vy !== 10'd0) begin failures++; $display("FAIL kick_neg got (%0d,%0d) exp (-5,0)", $signed(ball_vx), $signed(ball_vy)); end
    set_p(0, 320, 240, 0, 0);
    tick(1);
    checks++;
    if (ball_vx !== 10'(-5) || ball_x !== 10'd315) begin failures++; $display("FAIL still_player got vx=%0d x=%0d exp -5 315", $signed(ball_vx), ball_x); end
  endtask

  task automatic test_priority();
    park();
    set_p(0, 320, 240, 2, 0);
    set_p(1, 322, 240, -2, 0);
    go_play();
    tick(1);
    checks++;
    if (ball_vx !== 10'd5) begin failures++; $display("FAIL prio_p0 got vx=%0d exp 5", $signed(ball_vx)); end
    set_p(0, 320, 240, -2, 0);
    set_p(1, 322, 240, 2, 0);
    tick(1);
    checks++;
    if (ball_vx !== 10'(-5)) begin failures++; $display("FAIL prio_swap got vx=%0d exp -5", $signed(ball_vx)); end
  endtask

  task automatic test_friction();
    park();
    set_p(0, 320, 240, 1, -1);
    friction_en = 1'b1;
    go_play();
    tick(1);
    checks++;
    if (ball_vx !== 10'd4 || ball_vy !== 10'(-4)) begin failures++; $display("FAIL fric_kick got (%0d,%0d) exp (4,-4)", $signed(ball_vx), $signed(ball_vy)); end
    park();
    tick(1);
    checks++;
    if (ball_vx !== 10'd3 || ball_vy !== 10'(-3)) begin failures++; $display("FAIL fric_first got (%0d,%0d) exp (3,-3)", $signed(ball_vx), $signed(ball_vy)); end
    tick(4);
    checks++;
    if (ball_vx !== 10'd2 || ball_vy !== 10'(-2) || ball_x !== 10'd336 || ball_y !== 10'd224) begin failures++; $display("FAIL fric_second got v=(%0d,%0d) p=(%0d,%0d) exp (2,-2) (336,224)", $signed(ball_vx), $signed(ball_vy), ball_x, ball_y); end
    tick(11);
    checks++;
    if (ball_vx !== 10'd0 || ball_vy !== 10'd0) begin failures++; $display("FAIL fric_stop got (%0d,%0d) exp (0,0)", $signed(ball_vx), $signed(ball_vy)); end
    friction_en = 1'b0;
  endtask

  task automatic test_goal();
    park();
    set_p(0, 320, 240, -11, 0);
    go_play();
    tick(1);
    checks++;
    if (ball_vx !== 10'(-12)) begin failures++; $display("FAIL goal_kick got vx=%0d exp -12", $signed(ball_vx)); end
    park();
    tick(25);
    checks++;
    if (ball_x !== 10'd24 || phase !== 2'd1 || goal_left !== 1'b0) begin failures++; $display("FAIL goal_pre got x=%0d phase=%0d pulse=%b exp 24 1 0", ball_x, phase, goal_left); end
    tick(1);
    checks++;
    if (goal_left !== 1'b1 || goal_right !== 1'b0 || goals_left !== 4'd1 || phase !== 2'd2 || ball_vx !== 10'd0) begin failures++; $display("FAIL goal_hit got pulse=%b%b gl=%0d phase=%0d vx=%0d exp 10 1 2 0", goal_left, goal_right, goals_left, phase, $signed(ball_vx)); end
    tick(1);
    checks++;
    if (goal_left !== 1'b0 || phase !== 2'd2) begin failures++; $display("FAIL goal_pulse got pulse=%b phase=%0d exp 0 2", goal_left, phase); end
    tick(59);
    checks++;
    if (phase !== 2'd2) begin failures++; $display("FAIL hold_len got phase=%0d exp 2", phase); end
    tick(1);
    checks++;
    if (phase !== 2'd0 || ball_x !== 10'd320 || ball_y !== 10'd240) begin failures++; $display("FAIL hold_end got phase=%0d pos=(%0d,%0d) exp 0 (320,240)", phase, ball_x, ball_y); end
    tick(30);
    checks++;
    if (phase !== 2'd0) begin failures++; $display("FAIL reserve_hold got phase=%0d exp 0", phase); end
    tick(1);
    checks++;
    if (phase !== 2'd1 || goals_left !== 4'd1) begin failures++; $display("FAIL replay got phase=%0d gl=%0d exp 1 1", phase, goals_left); end
  endtask

  task automatic test_back_to_back();
    set_p(0, 320, 240, -11, 0);
    tick(1);
    park();
    tick(26);
    checks++;
    if (goal_left !== 1'b1 || goals_left !== 4'd2) begin failures++; $display("FAIL goal2 got pulse=%b gl=%0d exp 1 2", goal_left, goals_left); end
    tick(10);
    center_ball = 1'b1;
    tick(1);
    center_ball = 1'b0;
    checks++;
    if (phase !== 2'd0 || ball_x !== 10'd320 || ball_vx !== 10'd0 || goals_left !== 4'd2) begin failures++; $display("FAIL center_hold got phase=%0d x=%0d vx=%0d gl=%0d exp 0 320 0 2", phase, ball_x, $signed(ball_vx), goals_left); end
    tick(31);
    checks++;
    if (phase !== 2'd1) begin failures++; $display("FAIL center_replay got phase=%0d exp 1", phase); end
    set_p(0, 320, 240, -11, 0);
    tick(1);
    park();
    tick(25);
    center_ball = 1'b1;
    tick(1);
    center_ball = 1'b0;
    checks++;
    if (phase !== 2'd0 || goal_left !== 1'b0 || goals_left !== 4'd2 || ball_x !== 10'd320) begin failures++; $display("FAIL center_beats_goal got phase=%0d pulse=%b gl=%0d x=%0d exp 0 0 2 320", phase, goal_left, goals_left, ball_x); end
  endtask

  task automatic test_saturate();
    int exp_gl;
    for (int i = 0; i < 14; i++) begin
      tick(31);
      set_p(0, 320, 240, -11, 0);
      tick(1);
      park();
      tick(26);
      exp_gl = (3 + i > 15) ? 15 : 3 + i;
      checks++;
      if (goal_left !== 1'b1 || goals_left !== 4'(exp_gl)) begin failures++; $display("FAIL score_sat[%0d] got pulse=%b gl=%0d exp 1 %0d", i, goal_left, goals_left, exp_gl); end
      center_ball = 1'b1;
      tick(1);
      center_ball = 1'b0;
    end
    tick(31);
    set_p(0, 320, 240, 9, 0);
    tick(1);
    park();
    tick(26);
    checks++;
    if (goal_right !== 1'b1 || goal_left !== 1'b0 || goals_right !== 4'd1 || goals_left !== 4'd15 || phase !== 2'd2) begin failures++; $display("FAIL goal_right got pulse=%b%b gr=%0d gl=%0d phase=%0d exp 01 1 15 2", goal_left, goal_right, goals_right, goals_left, phase); end
    tick(5);
    Reset_n = 1'b0;
    tick(1);
    Reset_n = 1'b1;
    checks++;
    if (goals_left !== 4'd0 || goals_right !== 4'd0 || phase !== 2'd0 || ball_x !== 10'd320) begin failures++; $display("FAIL reset_in_hold got gl=%0d gr=%0d phase=%0d x=%0d exp 0 0 0 320", goals_left, goals_right, phase, ball_x); end
  endtask

  initial begin
    test_reset();
    test_wall();
    test_corner();
    test_kick_still();
    test_priority();
    test_friction();
    test_goal();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
